// File: rtl/exp4_unidade_controle_pkg.sv
// Shared definitions for the Experiment 4 control unit.
// Holds the fixed 4-bit state encodings (also shown on the 7-segment debug
// display and used by the datapath to gate its timeout counter) and a small
// helper that tells whether a state ends the game.
package exp4_unidade_controle_pkg;

   // The encodings are fixed because they leave the block through db_estado.
   // The datapath only counts timeout while db_estado equals 4'h3.
   typedef enum logic [3:0] {
      inicial       = 4'h0,
      preparacao    = 4'h1,
      espera_jogada = 4'h3,
      registra      = 4'h4,
      comparacao    = 4'h5,
      proximo       = 4'h6,
      fim_acertou   = 4'hA,
      fim_timeout   = 4'hD,
      fim_errou     = 4'hE
   } estado_t;

   // True for the three states in which the game is over.
   function automatic logic is_terminal(estado_t e);
      return (e == fim_acertou) || (e == fim_errou) || (e == fim_timeout);
   endfunction

endpackage

// File: rtl/exp4_unidade_controle.sv
// exp4_unidade_controle
// Moore control unit that sequences the Experiment 4 datapath through one
// game of 16 plays: wait for iniciar, clear the datapath, then for each ROM
// position wait for a play, register it, compare it and advance. The game
// ends all correct, on a wrong play, or on a play timeout.
//
// Ports
//   clock            system clock, rising edge
//   reset            synchronous, active-high, returns to inicial
//   iniciar          start / restart from inicial or a terminal state
//   fimC             address counter is at its last position (15)
//   igual            registered play matches the current ROM word
//   jogada_feita     one-cycle play pulse from the edge detector
//   controle_timeout timeout counter reached its end
//   zeraC            clear address counter, edge detector, timeout counter
//   contaC           advance address (also clears the timeout counter)
//   zeraR            clear play register and timeout counter
//   registraR        load play register
//   pronto           game over (any terminal state)
//   acertou          game over, all plays correct
//   errou            game over on a wrong play
//   timeout          game over on a play timeout
//   db_estado        current state encoding
module exp4_unidade_controle
   import exp4_unidade_controle_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       fimC,
   input  logic       igual,
   input  logic       jogada_feita,
   input  logic       controle_timeout,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   estado_t estado_atual;
   estado_t proximo_estado;

   // State register; reset is synchronous and overrides every input.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_atual <= inicial;
      end else begin
         estado_atual <= proximo_estado;
      end
   end

   // Next-state logic. A play arriving together with a timeout wins, and
   // terminal states go straight to preparacao so a held iniciar restarts
   // the game only once. Any unused encoding falls back to inicial.
   always_comb begin
      proximo_estado = inicial;
      case (estado_atual)
         inicial:       proximo_estado = iniciar ? preparacao : inicial;
         preparacao:    proximo_estado = espera_jogada;
         espera_jogada: begin
            if (jogada_feita) begin
               proximo_estado = registra;
            end else if (controle_timeout) begin
               proximo_estado = fim_timeout;
            end else begin
               proximo_estado = espera_jogada;
            end
         end
         registra:      proximo_estado = comparacao;
         comparacao: begin
            if (!igual) begin
               proximo_estado = fim_errou;
            end else if (fimC) begin
               proximo_estado = fim_acertou;
            end else begin
               proximo_estado = proximo;
            end
         end
         proximo:       proximo_estado = espera_jogada;
         fim_acertou,
         fim_errou,
         fim_timeout:   proximo_estado = iniciar ? preparacao : estado_atual;
         default:       proximo_estado = inicial;
      endcase
   end

   // Moore outputs, decoded from the state register only.
   always_comb begin
      zeraC     = 1'b0;
      contaC    = 1'b0;
      zeraR     = 1'b0;
      registraR = 1'b0;
      acertou   = 1'b0;
      errou     = 1'b0;
      timeout   = 1'b0;
      case (estado_atual)
         preparacao: begin
            zeraC = 1'b1;
            zeraR = 1'b1;
         end
         registra:    registraR = 1'b1;
         proximo:     contaC    = 1'b1;
         fim_acertou: acertou   = 1'b1;
         fim_errou:   errou     = 1'b1;
         fim_timeout: timeout   = 1'b1;
         default: ;
      endcase
   end

   assign pronto    = is_terminal(estado_atual);
   assign db_estado = estado_atual;

endmodule
